// File: rtl/address_generator_2d_pkg.sv
// Shared types and default widths for the 2-D raster address generator.
package address_gen_pkg;

  localparam int ADDR_W = 16;
  localparam int DIM_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/address_generator_2d_if.sv
// Address stream: addr with valid/ready handshake and end-of-frame marker.
interface address_generator_2d_if #(
  parameter int ADDR_W = address_gen_pkg::ADDR_W
) ();

  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;
  logic              last;

  modport master (
    output addr,
    output addr_valid,
    output last,
    input  addr_ready
  );

  modport slave (
    input  addr,
    input  addr_valid,
    input  last,
    output addr_ready
  );

endinterface

// File: rtl/address_generator_2d_dim_counter.sv
// Wrapping counter over 0..limit-1 with terminal flag at limit-1.
module dim_counter #(
  parameter int DIM_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIM_W-1:0] limit,
  output logic [DIM_W-1:0] count,
  output logic             terminal
);

  assign terminal = (count == limit - DIM_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + DIM_W'(1);
    end
  end

endmodule

// File: rtl/address_generator_2d.sv
// 2-D raster address generator: rows x cols addresses from base,
// rows pitch apart, streamed over valid/ready with a last marker.
module address_generator_2d
  import address_gen_pkg::*;
#(
  parameter int ADDR_W = address_gen_pkg::ADDR_W,
  parameter int DIM_W  = address_gen_pkg::DIM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] pitch,
  input  logic [DIM_W-1:0]  cols,
  input  logic [DIM_W-1:0]  rows,
  output logic              busy,
  output logic              done,
  address_generator_2d_if.master stream
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] pitch_q;
  logic [DIM_W-1:0]  cols_q;
  logic [DIM_W-1:0]  rows_q;
  logic              cont_q;

  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic              col_term;
  logic              row_term;
  logic              frame_end;
  logic              accept;
  logic              xfer;
  logic              clr;
  logic [ADDR_W-1:0] next_row;

  assign accept = (state_q == IDLE) && start && !stop
                  && (cols != '0) && (rows != '0);
  assign xfer      = (state_q == RUN) && stream.addr_ready;
  assign clr       = accept || stop;
  assign frame_end = col_term && row_term;
  assign next_row  = row_base_q + pitch_q;

  dim_counter #(.DIM_W(DIM_W)) u_col (
    .clock    (clock),
    .reset    (reset),
    .enable   (xfer),
    .clear    (clr),
    .limit    (cols_q),
    .count    (col),
    .terminal (col_term)
  );

  dim_counter #(.DIM_W(DIM_W)) u_row (
    .clock    (clock),
    .reset    (reset),
    .enable   (xfer && col_term),
    .clear    (clr),
    .limit    (rows_q),
    .count    (row),
    .terminal (row_term)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = RUN;
        RUN:     if (xfer && frame_end && !cont_q) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      pitch_q <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
      cont_q  <= 1'b0;
    end else if (accept) begin
      base_q  <= base;
      pitch_q <= pitch;
      cols_q  <= cols;
      rows_q  <= rows;
      cont_q  <= continuous;
    end
  end

  // Row ends and frame wrap load the next row start directly: no bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      row_base_q <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          addr_q     <= base;
          row_base_q <= base;
        end
        xfer && !col_term: begin
          addr_q <= addr_q + ADDR_W'(1);
        end
        xfer && frame_end && cont_q: begin
          addr_q     <= base_q;
          row_base_q <= base_q;
        end
        xfer && col_term && !(frame_end && cont_q): begin
          addr_q     <= next_row;
          row_base_q <= next_row;
        end
        default: ;
      endcase
    end
  end

  assign stream.addr       = addr_q;
  assign stream.addr_valid = (state_q == RUN);
  assign stream.last       = (state_q == RUN) && frame_end;
  assign busy              = (state_q == RUN);
  assign done              = (state_q == DONE);

endmodule

// File: tb/tb_address_generator_2d.sv
// Directed self-checking bench for address_generator_2d.
module tb_address_generator_2d;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] base = '0;
  logic [15:0] pitch = '0;
  logic [7:0]  cols = '0;
  logic [7:0]  rows = '0;
  logic        busy;
  logic        done;

  int tests = 0;
  int failed = 0;

  address_generator_2d_if #(.ADDR_W(16)) bus ();

  address_generator_2d #(.ADDR_W(16), .DIM_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .base       (base),
    .pitch      (pitch),
    .cols       (cols),
    .rows       (rows),
    .busy       (busy),
    .done       (done),
    .stream     (bus.master)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input logic [15:0] b, input logic [15:0] p,
                     input logic [7:0] c, input logic [7:0] r);
    base  = b;
    pitch = p;
    cols  = c;
    rows  = r;
  endtask

  logic [15:0] seq1 [6];
  logic [15:0] seq2 [4];

  initial begin
    int idx;
    seq1 = '{16'h0100, 16'h0101, 16'h0102, 16'h0140, 16'h0141, 16'h0142};
    seq2 = '{16'h0010, 16'h0011, 16'h0020, 16'h0021};
    bus.addr_ready = 1'b1;

    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_addr", 32'(bus.addr), 32'h0);
    chk("rst_valid", 32'(bus.addr_valid), 32'h0);
    chk("rst_last", 32'(bus.last), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    // one-shot, ready held high
    cfg(16'h0100, 16'h0040, 8'd3, 8'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("os_addr%0d", i), 32'(bus.addr), 32'(seq1[i]));
      chk($sformatf("os_valid%0d", i), 32'(bus.addr_valid), 32'h1);
      chk($sformatf("os_last%0d", i), 32'(bus.last), 32'(i == 5));
      chk($sformatf("os_done%0d", i), 32'(done), 32'h0);
      tick();
    end
    chk("os_done", 32'(done), 32'h1);
    chk("os_dvalid", 32'(bus.addr_valid), 32'h0);
    tick();
    chk("os_done_off", 32'(done), 32'h0);
    chk("os_idle_busy", 32'(busy), 32'h0);

    // backpressure, ready pattern 1,0,0 repeating
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      bus.addr_ready = (c % 3 == 0);
      chk($sformatf("bp_addr_c%0d", c), 32'(bus.addr), 32'(seq1[idx]));
      chk($sformatf("bp_last_c%0d", c), 32'(bus.last), 32'(idx == 5));
      if (bus.addr_ready) idx++;
      tick();
    end
    chk("bp_count", 32'(idx), 32'd6);
    chk("bp_done", 32'(done), 32'h1);
    bus.addr_ready = 1'b1;
    tick();

    // continuous frames; config may change after capture
    cfg(16'h0010, 16'h0010, 8'd2, 8'd2);
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    continuous = 1'b0;
    cfg(16'h0aaa, 16'h0bbb, 8'd7, 8'd7);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("ct_addr%0d", i), 32'(bus.addr), 32'(seq2[i % 4]));
      chk($sformatf("ct_last%0d", i), 32'(bus.last), 32'(i % 4 == 3));
      chk($sformatf("ct_done%0d", i), 32'(done), 32'h0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ct_stop_valid", 32'(bus.addr_valid), 32'h0);
    chk("ct_stop_done", 32'(done), 32'h0);

    // stop after two transfers
    cfg(16'h0100, 16'h0040, 8'd3, 8'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ab_addr", 32'(bus.addr), 32'h0102);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ab_valid", 32'(bus.addr_valid), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_done", 32'(done), 32'h0);
    tick();
    chk("ab_done2", 32'(done), 32'h0);

    // restart after abort, 1x1 frame
    cfg(16'h0200, 16'h0001, 8'd1, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("one_addr", 32'(bus.addr), 32'h0200);
    chk("one_valid", 32'(bus.addr_valid), 32'h1);
    chk("one_last", 32'(bus.last), 32'h1);
    tick();
    chk("one_done", 32'(done), 32'h1);
    tick();

    // async reset mid-frame
    cfg(16'h0300, 16'h0010, 8'd3, 8'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ar_pre", 32'(bus.addr), 32'h0301);
    #2 reset = 1'b1;
    #1;
    chk("ar_addr", 32'(bus.addr), 32'h0);
    chk("ar_valid", 32'(bus.addr_valid), 32'h0);
    chk("ar_last", 32'(bus.last), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_done", 32'(done), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_after_done", 32'(done), 32'h0);

    // zero dimensions ignored
    cfg(16'h0100, 16'h0040, 8'd0, 8'd2);
    start = 1'b1;
    tick();
    chk("z_cols", 32'(busy), 32'h0);
    cfg(16'h0100, 16'h0040, 8'd2, 8'd0);
    tick();
    chk("z_rows", 32'(busy), 32'h0);

    // stop beats start in IDLE
    cfg(16'h0100, 16'h0040, 8'd2, 8'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    chk("ss_busy", 32'(busy), 32'h0);

    // wrap past all-ones; start during RUN and DONE ignored
    cfg(16'hffff, 16'h0000, 8'd2, 8'd1);
    start = 1'b1;
    tick();
    chk("wr_addr0", 32'(bus.addr), 32'hffff);
    chk("wr_last0", 32'(bus.last), 32'h0);
    cfg(16'h0500, 16'h0000, 8'd5, 8'd5);
    tick();
    chk("wr_addr1", 32'(bus.addr), 32'h0000);
    chk("wr_last1", 32'(bus.last), 32'h1);
    tick();
    chk("wr_done", 32'(done), 32'h1);
    chk("wr_dbusy", 32'(busy), 32'h0);
    start = 1'b0;
    tick();
    chk("wr_idle", 32'(busy), 32'h0);
    chk("wr_idle_done", 32'(done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/address_generator_2d.md
# address_generator_2d

Parametrised 2-D raster address generator, successor to the single-channel linear address counter. It walks a rectangular region of a memory: `rows` × `cols` addresses starting at `base`, with consecutive rows `pitch` apart. Addresses go out on a valid/ready stream with a `last` marker, and the block supports one-shot or continuous frames plus abort. It sits between the frame/window controller and memory read ports of the image-processing datapaths.

## Interface
Parameters:
- `ADDR_W`, 16: width of base, pitch, addr
- `DIM_W`, 8: width of rows/cols counts

Ports:
- `clock`  in  1  clock; all logic on rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a frame; honoured only in IDLE
- `stop`  in  1  abort; honoured in any state
- `continuous`  in  1  sampled with `start`; 1 = restart frame at `base` after last address
- `base`  in  ADDR_W  first address; sampled with `start`
- `pitch`  in  ADDR_W  address distance between row starts; sampled with `start`
- `cols`  in  DIM_W  addresses per row, 1..2^DIM_W-1; sampled with `start`
- `rows`  in  DIM_W  rows per frame, 1..2^DIM_W-1; sampled with `start`
- `addr`  out  ADDR_W  current address
- `addr_valid`  out  1  `addr` is valid
- `addr_ready`  in  1  consumer accepts `addr`
- `last`  out  1  `addr` is final address of the frame (qualified by `addr_valid`)
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse at completion of a one-shot frame

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 with `cols`≠0 and `rows`≠0 captures all config and moves to RUN.
  - If either dimension is 0, `start` is ignored and the state stays IDLE.
- **RUN:**
  - `addr_valid`=1 throughout RUN.
  - A transfer occurs when `addr_valid` & `addr_ready`.
  - Without a transfer, `addr`, `last` and the counters hold.
- **Advance on transfer:**
  - If `col` < cols-1: `col`+1, `addr`+1.
  - Else: `col`=0, `row`+1, `row_base` += `pitch`, `addr` = new `row_base`.
- **`last`** = (`col`==cols-1) & (`row`==rows-1).
- **Transfer with `last`=1:**
  - `continuous`=1: `col`=`row`=0, `addr`=`row_base`=`base`; state stays RUN; no `done`.
  - `continuous`=0: go to DONE.
- **DONE:**
  - `done`=1 and `addr_valid`=0 for exactly one cycle, then IDLE.
  - `start` is ignored in DONE.
- **Arithmetic:** all address arithmetic is modulo 2^ADDR_W; wrap past all-ones is legal and silent.
- **`stop`:**
  - `stop`=1 in any state forces IDLE on the next edge.
  - `addr_valid` drops that edge; no `done` is produced.
  - `stop` and `start` together in IDLE: `stop` wins.
- `start` while RUN is ignored. Config inputs may change freely after capture.
- **Reset values:** state IDLE; `addr`=0, `addr_valid`=0, `last`=0, `busy`=0, `done`=0; internal `col`/`row`/`row_base`=0.
- **Reset mid-frame:** immediate abort to these values; no `done`.

## Timing
- `start` sampled at edge N: `addr_valid`=1 with `addr`=`base` from edge N+1. `busy` follows the same timing.
- Throughput is 1 address/cycle with `addr_ready` held high; there are no bubbles at row ends or continuous frame wrap.
- **`done`:**
  - Asserted the cycle after the final transfer.
  - Earliest next accepted `start` is the cycle after `done`.
  - One-shot frame of R×C with `ready`=1 occupies R·C RUN cycles + 1 DONE cycle.
- **Outputs:**
  - All outputs are registered; no combinational path from `addr_ready` to any output.
  - `addr`/`last` change only on transfer, frame start, `stop` or reset.

## Structure
- Shared package `address_gen_pkg`: state encoding (IDLE, RUN, DONE) and default widths ADDR_W=16, DIM_W=8.
- Sub-module `dim_counter` (DIM_W parameter): count-enable, synchronous clear, terminal-count output at limit-1, wrap to 0.
  - Instantiated twice: column enabled on transfer; row enabled on transfer & column terminal.
  - The top computes `last` from both terminal outputs.

## Test plan
- **One-shot, continuous ready:** base=0x0100, pitch=0x0040, cols=3, rows=2, ready=1.
  - Addrs 0x0100, 0x0101, 0x0102, 0x0140, 0x0141, 0x0142 on consecutive cycles.
  - `last` only with 0x0142; `done` one cycle later; then idle.
- **Backpressure:** same config, `addr_ready` toggling 1,0,0,1,…
  - `addr` holds through stalls; the same 6-address sequence with no skips or duplicates.
- **Continuous:** cols=2, rows=2, base=0x10, pitch=0x10, continuous=1.
  - 0x10, 0x11, 0x20, 0x21, 0x10, …; `last` every 4th address; `done` never asserts.
- **Abort and reset mid-frame:**
  - `stop` after 2 transfers: `addr_valid`=0 next cycle, no `done`, new `start` accepted.
  - Async `reset` mid-frame: all outputs 0 immediately.
- **Edge configs:**
  - cols=0 or rows=0 `start` is ignored (`busy` stays 0).
  - cols=1, rows=1 gives a single address with `last`=1.
  - base=0xFFFF, cols=2 wraps to 0x0000.
  - `start` during RUN is ignored.
